// File: rtl/palette_layer_compositor.sv
// -----------------------------------------------------------------------------
// palette_layer_compositor
//
// Pipelined palette decoder and layer compositor for the VGA pixel path. Each
// pixel carries one palette index per layer. Every index is looked up in that
// layer's own runtime-writable 12-bit RGB palette. The topmost non-transparent
// layer wins. If every layer is transparent, bg_color is emitted instead.
//
// After reset a CLEAR sequence zeroes every palette entry. ready stays low
// until the sequence completes.
//
// Optional feature (macro PALETTE_FADE_EN): adds a 4th stage that scales each
// colour channel by (fade_level+1)/16. This raises the latency from 3 to 4.
//
// Parameters:
//   LAYERS     number of layers (1..4); layer LAYERS-1 is the top
//   IDX_W      palette index width; each palette holds 2**IDX_W entries
//   TRANSP_IDX index value treated as transparent
//
// Ports:
//   clk, rst_n  pixel clock, synchronous active-low reset
//   in_valid    pixel index vector valid
//   in_idx      layer k index at [k*IDX_W +: IDX_W]
//   wr_en       palette write strobe
//   wr_layer    target layer of the write (values >= LAYERS are dropped)
//   wr_addr     palette entry address of the write
//   wr_data     RGB 4:4:4 colour to store
//   bg_color    colour used when every layer is transparent
//   fade_level  brightness, 15 = full (fade build only)
//   ready       clear done; pixels and writes are accepted
//   out_valid   out_pixel valid
//   out_pixel   composited RGB
//   out_layer   winning layer (0 when bg_color was used)
//   out_bg      bg_color was used
// -----------------------------------------------------------------------------
module palette_layer_compositor #(
  parameter int LAYERS     = 2,
  parameter int IDX_W      = 7,
  parameter int TRANSP_IDX = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [LAYERS*IDX_W-1:0] in_idx,
  input  logic                    wr_en,
  input  logic [1:0]              wr_layer,
  input  logic [IDX_W-1:0]        wr_addr,
  input  logic [11:0]             wr_data,
  input  logic [11:0]             bg_color,
  input  logic [3:0]              fade_level,
  output logic                    ready,
  output logic                    out_valid,
  output logic [11:0]             out_pixel,
  output logic [1:0]              out_layer,
  output logic                    out_bg
);

  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic             clear_we;

  // ---------------------------------------------------------------------------
  // Control FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of statement order.
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      CLEAR:   if (&cnt) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    clear_we = 1'b0;
    case (state)
      CLEAR:   clear_we = 1'b1;
      RUN:     ready    = 1'b1;
      default: ;
    endcase
  end

  // Shared write port. During CLEAR every layer is zeroed at address cnt.
  logic [IDX_W-1:0] ram_addr;
  logic [11:0]      ram_data;

  always_comb begin
    ram_addr = clear_we ? cnt   : wr_addr;
    ram_data = clear_we ? 12'h0 : wr_data;
  end

  // ---------------------------------------------------------------------------
  // S1: register the input pixel
  // ---------------------------------------------------------------------------
  logic                    s1_valid;
  logic [LAYERS*IDX_W-1:0] s1_idx;
  logic [11:0]             s1_bg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_bg    <= '0;
    end else begin
      s1_valid <= in_valid && ready;
      s1_idx   <= in_idx;
      s1_bg    <= bg_color;
    end
  end

  // ---------------------------------------------------------------------------
  // Palettes + S2: synchronous read of every layer at its index
  // ---------------------------------------------------------------------------
  logic [LAYERS*12-1:0] s2_color;
  logic [LAYERS-1:0]    s2_transp;
  logic                 s2_valid;
  logic [11:0]          s2_bg;

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    logic [11:0] mem [DEPTH];
    logic [11:0] rd;
    logic        we;

    // A layer code matching k implies wr_layer < LAYERS, so out-of-range
    // writes fall through without touching any palette.
    assign we = rst_n && (clear_we || (ready && wr_en && wr_layer == 2'(k)));

    // NOTE: the palette array has no reset; the CLEAR sequence zeroes it, which
    // keeps it mappable to block RAM.
    // The read samples mem before this edge's write lands, which gives the
    // read-first collision behaviour.
    always_ff @(posedge clk) begin
      if (we) mem[ram_addr] <= ram_data;
      rd <= mem[s1_idx[k*IDX_W +: IDX_W]];
    end

    assign s2_color[k*12 +: 12] = rd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_transp <= '0;
      s2_bg     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_bg    <= s1_bg;
      for (int k = 0; k < LAYERS; k++)
        s2_transp[k] <= (s1_idx[k*IDX_W +: IDX_W] == IDX_W'(TRANSP_IDX));
    end
  end

  // ---------------------------------------------------------------------------
  // S3: compose. The top layer wins. Layer 0 is the last resort before bg.
  // ---------------------------------------------------------------------------
  logic        found;
  logic [11:0] c_pixel;
  logic [1:0]  c_layer;
  logic        c_bg;

  always_comb begin
    found   = 1'b0;
    c_pixel = s2_bg;
    c_layer = 2'd0;
    c_bg    = 1'b1;
    for (int k = LAYERS - 1; k >= 1; k--) begin
      if (!found && !s2_transp[k]) begin
        found   = 1'b1;
        c_pixel = s2_color[k*12 +: 12];
        c_layer = 2'(k);
        c_bg    = 1'b0;
      end
    end
    if (!found && !s2_transp[0]) begin
      c_pixel = s2_color[11:0];
      c_layer = 2'd0;
      c_bg    = 1'b0;
    end
  end

`ifdef PALETTE_FADE_EN
  // c * (level+1) / 16: level 15 is the identity and level 0 gives black.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] lvl);
    logic [8:0] p;
    p = {5'd0, c} * ({5'd0, lvl} + 9'd1);
    return p[7:4];
  endfunction

  logic        s3_valid;
  logic [11:0] s3_pixel;
  logic [1:0]  s3_layer;
  logic        s3_bg;
  logic [3:0]  s3_fade;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_pixel <= '0;
      s3_layer <= '0;
      s3_bg    <= 1'b0;
      s3_fade  <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_fade  <= fade_level;
      if (s2_valid) begin
        s3_pixel <= c_pixel;
        s3_layer <= c_layer;
        s3_bg    <= c_bg;
      end
    end
  end

  // S4: brightness scaling, with layer/bg delayed alongside the pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_layer <= '0;
      out_bg    <= 1'b0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        out_pixel <= {scale(s3_pixel[11:8], s3_fade),
                      scale(s3_pixel[7:4],  s3_fade),
                      scale(s3_pixel[3:0],  s3_fade)};
        out_layer <= s3_layer;
        out_bg    <= s3_bg;
      end
    end
  end
`else
  // The signal name marks fade_level as deliberately unused in this build.
  logic unused_fade;
  assign unused_fade = ^fade_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_layer <= '0;
      out_bg    <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_pixel <= c_pixel;
        out_layer <= c_layer;
        out_bg    <= c_bg;
      end
    end
  end
`endif

endmodule

// File: tb/tb_palette_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_palette_layer_compositor
//
// Self-checking bench for palette_layer_compositor with its default parameters
// (LAYERS=2, IDX_W=7). The stimulus tasks push the expected pixel and its
// arrival cycle into a scoreboard queue. A negedge monitor pops one entry for
// each out_valid and compares it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_palette_layer_compositor;

`ifdef PALETTE_FADE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [13:0] in_idx;
  logic        wr_en;
  logic [1:0]  wr_layer;
  logic [6:0]  wr_addr;
  logic [11:0] wr_data;
  logic [11:0] bg_color;
  logic [3:0]  fade_level;
  logic        ready;
  logic        out_valid;
  logic [11:0] out_pixel;
  logic [1:0]  out_layer;
  logic        out_bg;

  palette_layer_compositor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_idx     (in_idx),
    .wr_en      (wr_en),
    .wr_layer   (wr_layer),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .bg_color   (bg_color),
    .fade_level (fade_level),
    .ready      (ready),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_layer  (out_layer),
    .out_bg     (out_bg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] pixel;
    logic [1:0]  layer;
    logic        bg;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] pal [2][128];
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] fade4(input logic [3:0] c, input logic [3:0] lvl);
`ifdef PALETTE_FADE_EN
    return 4'((int'(c) * (int'(lvl) + 1)) / 16);
`else
    return c;
`endif
  endfunction

  // Reference model: layer 1 beats layer 0, index 0 is transparent.
  function automatic exp_t model(input logic [6:0] i1, input logic [6:0] i0);
    exp_t e;
    if (i1 != 0)      begin e.pixel = pal[1][i1]; e.layer = 2'd1; e.bg = 1'b0; end
    else if (i0 != 0) begin e.pixel = pal[0][i0]; e.layer = 2'd0; e.bg = 1'b0; end
    else              begin e.pixel = bg_color;   e.layer = 2'd0; e.bg = 1'b1; end
    e.pixel = {fade4(e.pixel[11:8], fade_level), fade4(e.pixel[7:4], fade_level),
               fade4(e.pixel[3:0], fade_level)};
    e.cyc = cyc + LAT;
    return e;
  endfunction

  task automatic write(input logic [1:0] layer, input logic [6:0] addr, input logic [11:0] data);
    wr_en = 1'b1; wr_layer = layer; wr_addr = addr; wr_data = data;
    if (layer < 2) pal[layer][addr] = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Issue one pixel; the model expectation is pushed when push=1.
  task automatic send(input logic [6:0] i1, input logic [6:0] i0, input bit push);
    in_idx = {i1, i0}; in_valid = 1'b1;
    if (push) sb.push_back(model(i1, i0));
    tick();
    in_valid = 1'b0;
  endtask

  // Issue one pixel with a hand-computed expectation.
  task automatic send_exp(input logic [6:0] i1, input logic [6:0] i0,
                          input logic [11:0] px, input logic [1:0] ly, input logic bg);
    exp_t e;
    e.pixel = px; e.layer = ly; e.bg = bg; e.cyc = cyc + LAT;
    in_idx = {i1, i0}; in_valid = 1'b1;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles until ready. With noisy=1, in_valid and a write are driven
  // through most of CLEAR; both must be ignored.
  task automatic wait_ready(input bit noisy);
    int n = 0;
    do begin
      in_valid = noisy && (n < 100);
      wr_en    = noisy && (n < 100);
      wr_layer = 2'd0; wr_addr = 7'd3; wr_data = 12'hFFF; in_idx = {7'd9, 7'd3};
      tick();
      n++;
    end while (!ready && n < 1000);
    in_valid = 1'b0; wr_en = 1'b0;
    check("clear_cycles", n, 128);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin tick(); n++; end
    check("drain", sb.size(), 0);
    tick();
  endtask

  // Monitor: one scoreboard entry per output pixel, checked for value and cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_pixel: got %h layer %0d, required no output (cycle %0d)",
                   out_pixel, out_layer, cyc);
        end else begin
          e = sb.pop_front();
          check("pixel", {out_pixel, out_layer, out_bg}, {e.pixel, e.layer, e.bg});
          check("latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; wr_en = 1'b0; wr_layer = '0;
    wr_addr = '0; wr_data = '0; bg_color = 12'h777; fade_level = 4'd15;
    for (int l = 0; l < 2; l++) for (int a = 0; a < 128; a++) pal[l][a] = 12'h000;
    repeat (3) tick();

    // Reset state
    check("reset_ready", ready, 0);
    check("reset_outputs", {out_valid, out_pixel, out_layer, out_bg}, 0);

    // Clear sequence, then a first pixel on the freshly cleared palettes
    rst_n = 1'b1;
    wait_ready(1'b0);
    send_exp(7'd5, 7'd5, 12'h000, 2'd1, 1'b0);
    drain();

    // Priority, back-to-back
    write(2'd0, 7'd3, 12'hFC8);
    write(2'd1, 7'd9, 12'h2D8);
    send_exp(7'd9, 7'd3, 12'h2D8, 2'd1, 1'b0);
    send_exp(7'd0, 7'd3, 12'hFC8, 2'd0, 1'b0);
    send_exp(7'd0, 7'd0, 12'h777, 2'd0, 1'b1);
    drain();

    // Read/write collision: the write lands on the edge of the S2 read
    in_idx = {7'd9, 7'd3}; in_valid = 1'b1;
    send_exp(7'd9, 7'd3, 12'h2D8, 2'd1, 1'b0);
    write(2'd1, 7'd9, 12'h444);
    send_exp(7'd9, 7'd3, 12'h444, 2'd1, 1'b0);
    // Out-of-range layer write must not alias onto any palette
    write(2'd3, 7'd9, 12'hABC);
    write(2'd3, 7'd3, 12'hABC);
    send_exp(7'd9, 7'd3, 12'h444, 2'd1, 1'b0);
    send_exp(7'd0, 7'd3, 12'hFC8, 2'd0, 1'b0);
    drain();

    // Fade levels (the plain build ignores fade_level)
`ifdef PALETTE_FADE_EN
    fade_level = 4'd7;
    send_exp(7'd0, 7'd3, 12'h764, 2'd0, 1'b0);
    drain();
    fade_level = 4'd0;
    send_exp(7'd0, 7'd3, 12'h000, 2'd0, 1'b0);
    drain();
    fade_level = 4'd15;
    send_exp(7'd0, 7'd3, 12'hFC8, 2'd0, 1'b0);
    drain();
`else
    fade_level = 4'd0;
    send_exp(7'd0, 7'd3, 12'hFC8, 2'd0, 1'b0);
    drain();
    fade_level = 4'd15;
`endif

    // Streaming: 64 contiguous pixels against the model
    for (int i = 1; i < 16; i++) begin
      write(2'd0, 7'(i), 12'(12'h130 + i * 7));
      write(2'd1, 7'(i), 12'(12'h900 + i * 11));
    end
    for (int i = 0; i < 64; i++)
      send(7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)), 1'b1);
    drain();

    // Reset mid-stream with the pipeline full
    send(7'd1, 7'd2, 1'b0);
    send(7'd3, 7'd4, 1'b0);
    in_idx = {7'd5, 7'd6}; in_valid = 1'b1; rst_n = 1'b0;
    tick();
    check("midreset_outputs", {out_valid, out_pixel, out_layer, out_bg}, 0);
    check("midreset_ready", ready, 0);
    in_valid = 1'b0; rst_n = 1'b1;
    for (int l = 0; l < 2; l++) for (int a = 0; a < 128; a++) pal[l][a] = 12'h000;
    wait_ready(1'b1);
    repeat (8) tick();
    send_exp(7'd9, 7'd3, 12'h000, 2'd1, 1'b0);
    send_exp(7'd0, 7'd3, 12'h000, 2'd0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
